and_sweep_checker: RTL

// - On-chip exhaustive functional checker for the family of sized 6-input AND gate variants.
// - Drives one shared input vector to CHANNELS external AND instances and checks the selected channel output.

---
 rtl/and_sweep_checker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/and_sweep_checker.sv
// Exhaustive checker for the AND-gate variant array: sweeps every a_o pattern, compares y_i[ch] to &a_o.
// Each pattern takes SETTLE+1 cycles; a sweep is 2^WIDTH*(SETTLE+1) cycles. start is ignored while busy.
// Optional macro AND_SWEEP_ALLCH_EN checks all channels back to back and ignores ch_sel.
module and_sweep_checker #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 12,
  parameter int SETTLE   = 2,
  parameter int ERR_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CH_W-1:0]     ch_sel,
  output logic [WIDTH-1:0]    a_o,
  input  logic [CHANNELS-1:0] y_i,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [ERR_W-1:0]    err_cnt,
  output logic                fail_valid,
  output logic [WIDTH-1:0]    fail_pat,
  output logic [CH_W-1:0]     fail_ch
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int HC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(SETTLE - 1);
  localparam int YP = 1 << CH_W;

  logic [1:0]      state;
  logic [HC_W-1:0] hold_cnt;
  logic [CH_W-1:0] ch;
  logic [YP-1:0]   y_pad;
  logic            mismatch;

  // Zero-pad so any ch value indexes a real bit; only legal channels are ever selected.
  assign y_pad    = YP'(y_i);
  assign mismatch = (y_pad[ch] != (&a_o));

`ifdef AND_SWEEP_ALLCH_EN
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  logic unused_sel;
  assign unused_sel = ^ch_sel;
`else
  logic sel_bad;
  assign sel_bad = ({1'b0, ch_sel} >= (CH_W + 1)'(CHANNELS));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      ch         <= '0;
      a_o        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_pat   <= '0;
      fail_ch    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_pat   <= '0;
            fail_ch    <= '0;
            cfg_err    <= 1'b0;
            hold_cnt   <= '0;
`ifdef AND_SWEEP_ALLCH_EN
            ch    <= '0;
            a_o   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= HOLD;
`else
            if (sel_bad) begin
              // Bad channel: report immediately, a_o keeps its value.
              cfg_err <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              ch    <= ch_sel;
              a_o   <= '0;
              busy  <= 1'b1;
              done  <= 1'b0;
              state <= HOLD;
            end
`endif
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) state <= CHECK;
          else hold_cnt <= hold_cnt + 1'b1;
        end
        CHECK: begin
          hold_cnt <= '0;
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_pat   <= a_o;
              fail_ch    <= ch;
            end
          end
          if (a_o != '1) begin
            a_o   <= a_o + 1'b1;
            state <= HOLD;
          end
`ifdef AND_SWEEP_ALLCH_EN
          else if (ch != CH_LAST) begin
            ch    <= ch + 1'b1;
            a_o   <= '0;
            state <= HOLD;
          end
`endif
          else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
